// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg
//   Shared definitions for the ID/EX pipeline register slice: default
//   datapath widths, the zero-register specifier and the ALU opcode
//   encodings carried through the ALUOp field.
//   No ports; imported by id_ex_stage_reg and load_use_detect.
package id_ex_stage_reg_pkg;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;
  localparam int REG_W   = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // ALU opcodes as produced by the decoder; this stage only transports them.
  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard detector. Flags when the instruction in
//   EX is a valid load writing a non-zero register that the instruction in
//   ID actually reads through rs or rt.
//   Ports:
//     exValid_i, exMemRead_i, exRt_i : instruction currently in ID/EX
//     idValid_i, idRs_i, idRt_i      : instruction currently in IF/ID
//     idUsesRs_i, idUsesRt_i         : which source fields ID really reads
//     loadUse_o                      : hazard present this cycle
module load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic             exValid_i,
  input  logic             exMemRead_i,
  input  logic [REG_W-1:0] exRt_i,
  input  logic             idValid_i,
  input  logic [REG_W-1:0] idRs_i,
  input  logic [REG_W-1:0] idRt_i,
  input  logic             idUsesRs_i,
  input  logic             idUsesRt_i,
  output logic             loadUse_o
);

  logic loadInEx;
  logic rsDepends;
  logic rtDepends;

  // A load into $0 never produces a value anyone waits for.
  assign loadInEx  = exValid_i & exMemRead_i & (exRt_i != REG_ZERO);
  assign rsDepends = idUsesRs_i & (idRs_i == exRt_i);
  assign rtDepends = idUsesRt_i & (idRt_i == exRt_i);
  assign loadUse_o = loadInEx & idValid_i & (rsDepends | rtDepends);

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   ID/EX pipeline register with load-use hazard detection. Registers the
//   decoded controls, operands and register specifiers for EX, inserts one
//   bubble per load-use hazard (holding PC and IF/ID meanwhile), freezes on
//   a global hold and kills the entering instruction on an EX flush.
//   Ports:
//     clk, reset           : clock, synchronous active-high reset
//     hold, flush          : global freeze / branch-jump kill
//     IF_ID_*, ID_*        : instruction currently being decoded
//     ID_EX_*              : registered copies presented to EX / forwarding
//     PCWrite, IF_ID_Write : 0 = hold PC and IF/ID this cycle
//     BubbleCount          : saturating count of load-use bubbles
module id_ex_stage_reg #(
  parameter int DATA_W  = id_ex_stage_reg_pkg::DATA_W,
  parameter int ALUOP_W = id_ex_stage_reg_pkg::ALUOP_W,
  parameter int CNT_W   = id_ex_stage_reg_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               flush,
  input  logic               IF_ID_Valid,
  input  logic [4:0]         IF_ID_RegisterRs,
  input  logic [4:0]         IF_ID_RegisterRt,
  input  logic [4:0]         IF_ID_RegisterRd,
  input  logic               IF_ID_UsesRs,
  input  logic               IF_ID_UsesRt,
  input  logic               ID_Ctrl_RegWrite,
  input  logic               ID_Ctrl_MemRead,
  input  logic               ID_Ctrl_MemWrite,
  input  logic               ID_Ctrl_MemtoReg,
  input  logic               ID_Ctrl_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_Ctrl_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PCPlus4,
  output logic               ID_EX_Valid,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [DATA_W-1:0]  ID_EX_ReadData1,
  output logic [DATA_W-1:0]  ID_EX_ReadData2,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic [DATA_W-1:0]  ID_EX_PCPlus4,
  output logic [4:0]         ID_EX_RegisterRs,
  output logic [4:0]         ID_EX_RegisterRt,
  output logic [4:0]         ID_EX_RegisterRd,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  output logic [CNT_W-1:0]   BubbleCount
);

  import id_ex_stage_reg_pkg::*;

  logic               validQ, validD;
  logic               regWriteQ, regWriteD;
  logic               memReadQ, memReadD;
  logic               memWriteQ, memWriteD;
  logic               memtoRegQ, memtoRegD;
  logic               aluSrcQ, aluSrcD;
  logic [ALUOP_W-1:0] aluOpQ, aluOpD;
  logic [DATA_W-1:0]  readData1Q, readData1D;
  logic [DATA_W-1:0]  readData2Q, readData2D;
  logic [DATA_W-1:0]  immQ, immD;
  logic [DATA_W-1:0]  pcPlus4Q, pcPlus4D;
  logic [4:0]         rsQ, rsD;
  logic [4:0]         rtQ, rtD;
  logic [4:0]         rdQ, rdD;
  logic [CNT_W-1:0]   bubbleCountQ, bubbleCountD;

  logic loadUse;
  logic stall;

  load_use_detect uDetect (
    .exValid_i   (validQ),
    .exMemRead_i (memReadQ),
    .exRt_i      (rtQ),
    .idValid_i   (IF_ID_Valid),
    .idRs_i      (IF_ID_RegisterRs),
    .idRt_i      (IF_ID_RegisterRt),
    .idUsesRs_i  (IF_ID_UsesRs),
    .idUsesRt_i  (IF_ID_UsesRt),
    .loadUse_o   (loadUse)
  );

  // A flush makes the ID instruction dead, so a hazard against it is moot.
  assign stall       = loadUse & ~flush;
  assign PCWrite     = reset | (~stall & ~hold);
  assign IF_ID_Write = PCWrite;

  // Flush and load-use both squash to a bubble; only a real stall is counted.
  always_comb begin
    validD       = validQ;
    regWriteD    = regWriteQ;
    memReadD     = memReadQ;
    memWriteD    = memWriteQ;
    memtoRegD    = memtoRegQ;
    aluSrcD      = aluSrcQ;
    aluOpD       = aluOpQ;
    readData1D   = readData1Q;
    readData2D   = readData2Q;
    immD         = immQ;
    pcPlus4D     = pcPlus4Q;
    rsD          = rsQ;
    rtD          = rtQ;
    rdD          = rdQ;
    bubbleCountD = bubbleCountQ;
    if (hold) begin
      validD = validQ;
    end else if (flush || loadUse) begin
      validD     = 1'b0;
      regWriteD  = 1'b0;
      memReadD   = 1'b0;
      memWriteD  = 1'b0;
      memtoRegD  = 1'b0;
      aluSrcD    = 1'b0;
      aluOpD     = '0;
      readData1D = '0;
      readData2D = '0;
      immD       = '0;
      pcPlus4D   = '0;
      rsD        = REG_ZERO;
      rtD        = REG_ZERO;
      rdD        = REG_ZERO;
      if (stall && (bubbleCountQ != {CNT_W{1'b1}})) begin
        bubbleCountD = bubbleCountQ + CNT_W'(1);
      end
    end else begin
      validD     = IF_ID_Valid;
      regWriteD  = IF_ID_Valid & ID_Ctrl_RegWrite;
      memReadD   = IF_ID_Valid & ID_Ctrl_MemRead;
      memWriteD  = IF_ID_Valid & ID_Ctrl_MemWrite;
      memtoRegD  = ID_Ctrl_MemtoReg;
      aluSrcD    = ID_Ctrl_ALUSrc;
      aluOpD     = ID_Ctrl_ALUOp;
      readData1D = ID_ReadData1;
      readData2D = ID_ReadData2;
      immD       = ID_Imm;
      pcPlus4D   = ID_PCPlus4;
      rsD        = IF_ID_RegisterRs;
      rtD        = IF_ID_RegisterRt;
      rdD        = IF_ID_RegisterRd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ       <= 1'b0;
      regWriteQ    <= 1'b0;
      memReadQ     <= 1'b0;
      memWriteQ    <= 1'b0;
      memtoRegQ    <= 1'b0;
      aluSrcQ      <= 1'b0;
      aluOpQ       <= '0;
      readData1Q   <= '0;
      readData2Q   <= '0;
      immQ         <= '0;
      pcPlus4Q     <= '0;
      rsQ          <= REG_ZERO;
      rtQ          <= REG_ZERO;
      rdQ          <= REG_ZERO;
      bubbleCountQ <= '0;
    end else begin
      validQ       <= validD;
      regWriteQ    <= regWriteD;
      memReadQ     <= memReadD;
      memWriteQ    <= memWriteD;
      memtoRegQ    <= memtoRegD;
      aluSrcQ      <= aluSrcD;
      aluOpQ       <= aluOpD;
      readData1Q   <= readData1D;
      readData2Q   <= readData2D;
      immQ         <= immD;
      pcPlus4Q     <= pcPlus4D;
      rsQ          <= rsD;
      rtQ          <= rtD;
      rdQ          <= rdD;
      bubbleCountQ <= bubbleCountD;
    end
  end

  assign ID_EX_Valid      = validQ;
  assign ID_EX_RegWrite   = regWriteQ;
  assign ID_EX_MemRead    = memReadQ;
  assign ID_EX_MemWrite   = memWriteQ;
  assign ID_EX_MemtoReg   = memtoRegQ;
  assign ID_EX_ALUSrc     = aluSrcQ;
  assign ID_EX_ALUOp      = aluOpQ;
  assign ID_EX_ReadData1  = readData1Q;
  assign ID_EX_ReadData2  = readData2Q;
  assign ID_EX_Imm        = immQ;
  assign ID_EX_PCPlus4    = pcPlus4Q;
  assign ID_EX_RegisterRs = rsQ;
  assign ID_EX_RegisterRt = rtQ;
  assign ID_EX_RegisterRd = rdQ;
  assign BubbleCount      = bubbleCountQ;

endmodule
